// File: rtl/regfile_sb.sv
// regfile_sb: parametrised register file with two combinational read ports,
// store-operand steering on port B and a per-register busy scoreboard that
// raises Stall on read-after-write hazards.
// Optional feature macro: REGFILE_BYPASS_EN (write-to-read bypass; when
// defined, a read of the register being written this cycle returns the
// incoming writeback data and that port's hazard is suppressed).
module regfile_sb #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 3,
  parameter logic [3:0]  STORE_OP = 4'b0101,
  parameter bit          ZERO_R0  = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              WE_R,
  input  logic [ADDR_W-1:0] WrReg_Rd,
  input  logic [DATA_W-1:0] InData_R,
  input  logic [ADDR_W-1:0] ReadA,
  input  logic [ADDR_W-1:0] ReadB,
  input  logic [ADDR_W-1:0] ReadRd,
  input  logic [3:0]        opcode,
  input  logic              Issue,
  input  logic [ADDR_W-1:0] IssueDst,
  input  logic              IssueWr,
  output logic [DATA_W-1:0] OutA,
  output logic [DATA_W-1:0] OutB,
  output logic              Stall
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  logic [ADDR_W-1:0] sel_b;
  logic              wr_en;
  logic              set_en;
  logic              fwd_a;
  logic              fwd_b;
  logic              haz_a;
  logic              haz_b;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;

  // True when addr names the hard-wired zero register
  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] addr);
    return ZERO_R0 && (addr == '0);
  endfunction

  // Port B reads the store-data register for stores, ReadB otherwise
  assign sel_b = (opcode == STORE_OP) ? ReadRd : ReadB;

  // Writebacks to the zero register are dropped
  assign wr_en = WE_R & ~is_zero_reg(WrReg_Rd);

`ifdef REGFILE_BYPASS_EN
  // Forward the writeback data to any port reading the register being written;
  // held off during reset so every read returns zero while reset is high
  assign fwd_a = WE_R & ~reset & (WrReg_Rd == ReadA);
  assign fwd_b = WE_R & ~reset & (WrReg_Rd == sel_b);
`else
  // No bypass: reads always see the stored contents
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  // Combinational read ports with optional bypass and zero-register squash
  always_comb begin
    rd_a = regs_q[ReadA];
    rd_b = regs_q[sel_b];
    if (fwd_a) begin
      rd_a = InData_R;
    end
    if (fwd_b) begin
      rd_b = InData_R;
    end
    OutA = is_zero_reg(ReadA) ? '0 : rd_a;
    OutB = is_zero_reg(sel_b) ? '0 : rd_b;
  end

  // Hazard detection: a busy source stalls unless it is forwarded this cycle
  always_comb begin
    haz_a = busy_q[ReadA] & ~fwd_a & ~is_zero_reg(ReadA);
    haz_b = busy_q[sel_b] & ~fwd_b & ~is_zero_reg(sel_b);
    Stall = Issue & ~reset & (haz_a | haz_b);
  end

  // A non-stalled issue that writes a real register marks it busy
  assign set_en = Issue & IssueWr & ~Stall & ~is_zero_reg(IssueDst);

  // Next-state for the register array: one write per cycle from writeback
  always_comb begin
    regs_d = regs_q;
    if (wr_en) begin
      regs_d[WrReg_Rd] = InData_R;
    end
  end

  // Next-state for the scoreboard: writeback clears, then issue sets so a new
  // producer to the same register stays outstanding
  always_comb begin
    busy_d = busy_q;
    if (WE_R) begin
      busy_d[WrReg_Rd] = 1'b0;
    end
    if (set_en) begin
      busy_d[IssueDst] = 1'b1;
    end
  end

  // State registers with asynchronous reset clearing data and busy bits
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Stall can only be raised by an issuing instruction
  a_stall_needs_issue: assert property (@(posedge clk) disable iff (reset) Stall |-> Issue);

  // The zero register never carries a pending producer
  a_r0_never_busy: assert property (@(posedge clk) disable iff (reset) ZERO_R0 |-> !busy_q[0]);

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (ZERO_R0=0 and ZERO_R0=1) share stimulus;
// expected outputs are queued at drive time from a reference model and popped
// when the combinational outputs have settled. Directed checks add constants.
`timescale 1ns/1ps
module tb_regfile_sb;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned DEPTH  = 8;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              WE_R;
  logic [ADDR_W-1:0] WrReg_Rd;
  logic [DATA_W-1:0] InData_R;
  logic [ADDR_W-1:0] ReadA;
  logic [ADDR_W-1:0] ReadB;
  logic [ADDR_W-1:0] ReadRd;
  logic [3:0]        opcode;
  logic              Issue;
  logic [ADDR_W-1:0] IssueDst;
  logic              IssueWr;
  logic [DATA_W-1:0] outa0, outb0, outa1, outb1;
  logic              stall0, stall1;

  int checks = 0;
  int errors = 0;

  string             q_tag [$];
  int                q_sel [$];
  logic [DATA_W-1:0] q_exp [$];

  logic [DATA_W-1:0] m_regs [2][DEPTH];
  logic [DEPTH-1:0]  m_busy [2];

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STORE_OP(4'b0101), .ZERO_R0(1'b0)) dut0 (
    .clk(clk), .reset(reset), .WE_R(WE_R), .WrReg_Rd(WrReg_Rd), .InData_R(InData_R),
    .ReadA(ReadA), .ReadB(ReadB), .ReadRd(ReadRd), .opcode(opcode), .Issue(Issue),
    .IssueDst(IssueDst), .IssueWr(IssueWr), .OutA(outa0), .OutB(outb0), .Stall(stall0)
  );

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .STORE_OP(4'b0101), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .reset(reset), .WE_R(WE_R), .WrReg_Rd(WrReg_Rd), .InData_R(InData_R),
    .ReadA(ReadA), .ReadB(ReadB), .ReadRd(ReadRd), .opcode(opcode), .Issue(Issue),
    .IssueDst(IssueDst), .IssueWr(IssueWr), .OutA(outa1), .OutB(outb1), .Stall(stall1)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int z = 0; z < 2; z++) begin
      for (int i = 0; i < int'(DEPTH); i++) m_regs[z][i] = '0;
      m_busy[z] = '0;
    end
  endfunction

  function automatic logic [ADDR_W-1:0] m_selb();
    return (opcode == 4'b0101) ? ReadRd : ReadB;
  endfunction

  function automatic logic m_fwd(input logic [ADDR_W-1:0] a);
    return BYP && !reset && WE_R && (WrReg_Rd == a);
  endfunction

  function automatic logic [DATA_W-1:0] m_read(input int z, input logic [ADDR_W-1:0] a);
    if (z == 1 && a == 3'd0) return '0;
    if (m_fwd(a)) return InData_R;
    return m_regs[z][a];
  endfunction

  function automatic logic m_stall(input int z);
    logic ha, hb;
    logic [ADDR_W-1:0] b;
    if (reset || !Issue) return 1'b0;
    b  = m_selb();
    ha = m_busy[z][ReadA] && !m_fwd(ReadA) && !(z == 1 && ReadA == 3'd0);
    hb = m_busy[z][b] && !m_fwd(b) && !(z == 1 && b == 3'd0);
    return ha || hb;
  endfunction

  function automatic void m_update(input int z, input logic st);
    if (WE_R && !(z == 1 && WrReg_Rd == 3'd0)) m_regs[z][WrReg_Rd] = InData_R;
    if (WE_R) m_busy[z][WrReg_Rd] = 1'b0;
    if (Issue && IssueWr && !st && !(z == 1 && IssueDst == 3'd0)) m_busy[z][IssueDst] = 1'b1;
  endfunction

  function automatic logic [DATA_W-1:0] obs(input int sel);
    case (sel)
      0:       return outa0;
      1:       return outb0;
      2:       return DATA_W'(stall0);
      3:       return outa1;
      4:       return outb1;
      5:       return DATA_W'(stall1);
      default: return '0;
    endcase
  endfunction

  task automatic drive(input logic we, input logic [2:0] wr, input logic [15:0] din,
                       input logic [2:0] ra, input logic [2:0] rb, input logic [2:0] rd,
                       input logic [3:0] op, input logic iss, input logic [2:0] dst,
                       input logic iwr);
    WE_R = we; WrReg_Rd = wr; InData_R = din;
    ReadA = ra; ReadB = rb; ReadRd = rd; opcode = op;
    Issue = iss; IssueDst = dst; IssueWr = iwr;
  endtask

  // Queue model expectations for the current inputs, then compare after settling
  task automatic eval();
    for (int z = 0; z < 2; z++) begin
      q_tag.push_back($sformatf("d%0d_outa", z)); q_sel.push_back(3*z);     q_exp.push_back(m_read(z, ReadA));
      q_tag.push_back($sformatf("d%0d_outb", z)); q_sel.push_back(3*z + 1); q_exp.push_back(m_read(z, m_selb()));
      q_tag.push_back($sformatf("d%0d_stall", z)); q_sel.push_back(3*z + 2); q_exp.push_back(DATA_W'(m_stall(z)));
    end
    #2;
    while (q_sel.size() > 0) begin
      string tg;
      int sl;
      logic [DATA_W-1:0] ex;
      tg = q_tag.pop_front();
      sl = q_sel.pop_front();
      ex = q_exp.pop_front();
      check_eq(tg, 32'(obs(sl)), 32'(ex));
    end
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge
  task automatic tick();
    logic s0, s1;
    s0 = m_stall(0);
    s1 = m_stall(1);
    @(posedge clk);
    if (!reset) begin
      m_update(0, s0);
      m_update(1, s1);
    end
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    model_reset();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
    @(negedge clk);

    // Reads during reset: all zero, no stall even with issue/writeback active
    for (int a = 0; a < 8; a++) begin
      drive(1'b1, 3'(a), 16'hBEEF, 3'(a), 3'(7 - a), 3'd0, 4'h0, 1'b1, 3'(a), 1'b1);
      eval();
      check_eq("rst_outa", 32'(outa0), 32'h0);
      check_eq("rst_stall", 32'(stall0), 32'h0);
      tick();
    end
    reset = 1'b0;

    // First cycles after reset: every address reads zero
    for (int a = 0; a < 8; a++) begin
      drive(1'b0, 3'd0, 16'h0, 3'(a), 3'(a), 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
      eval();
      check_eq("post_rst_outa", 32'(outa0), 32'h0);
      check_eq("post_rst_outb", 32'(outb0), 32'h0);
      tick();
    end

    // Write latency on R3
    drive(1'b1, 3'd3, 16'hABCD, 3'd3, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("wr_cycle_outa", 32'(outa0), BYP ? 32'hABCD : 32'h0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd3, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("wr_after_outa", 32'(outa0), 32'hABCD);
    tick();

    // Store-operand steering on port B
    drive(1'b1, 3'd1, 16'h1111, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0); eval(); tick();
    drive(1'b1, 3'd5, 16'h5555, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0); eval(); tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 3'd5, 4'b0101, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("store_outb", 32'(outb0), 32'h5555);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 3'd5, 4'b0000, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("alu_outb", 32'(outb0), 32'h1111);
    tick();

    // RAW hazard on R2 and its resolution by writeback
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b1, 3'd2, 1'b1);
    eval();
    check_eq("issue_r2_stall", 32'(stall0), 32'h0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);
    eval();
    check_eq("raw_stall", 32'(stall0), 32'h1);
    check_eq("raw_stall_z", 32'(stall1), 32'h1);
    tick();
    drive(1'b1, 3'd2, 16'h2222, 3'd2, 3'd0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);
    eval();
    check_eq("wb_cycle_stall", 32'(stall0), BYP ? 32'h0 : 32'h1);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);
    eval();
    check_eq("wb_after_stall", 32'(stall0), 32'h0);
    check_eq("wb_after_outa", 32'(outa0), 32'h2222);
    tick();

    // Same-cycle set and clear on R4: set wins
    drive(1'b1, 3'd4, 16'h4444, 3'd0, 3'd0, 3'd0, 4'h0, 1'b1, 3'd4, 1'b1);
    eval();
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);
    eval();
    check_eq("set_wins_stall", 32'(stall0), 32'h1);
    // Asynchronous reset in the middle of the low phase
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("async_rst_outa", 32'(outa0), 32'h0);
    check_eq("async_rst_stall", 32'(stall0), 32'h0);
    tick();
    reset = 1'b0;
    drive(1'b1, 3'd4, 16'h0404, 3'd4, 3'd0, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);
    eval();
    check_eq("late_wb_stall", 32'(stall0), 32'h0);
    check_eq("late_wb_outa", 32'(outa0), BYP ? 32'h0404 : 32'h0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd4, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("late_wb_read", 32'(outa0), 32'h0404);
    tick();

    // Zero register behaviour (dut1) versus ordinary R0 (dut0)
    drive(1'b1, 3'd0, 16'hFFFF, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("r0_wr_cycle_z", 32'(outa1), 32'h0);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 3'd0, 4'h0, 1'b0, 3'd0, 1'b0);
    eval();
    check_eq("r0_read_z", 32'(outa1), 32'h0);
    check_eq("r0_read_nz", 32'(outa0), 32'hFFFF);
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd1, 3'd1, 3'd0, 4'h0, 1'b1, 3'd0, 1'b1);
    eval();
    tick();
    drive(1'b0, 3'd0, 16'h0, 3'd0, 3'd1, 3'd0, 4'h0, 1'b1, 3'd0, 1'b0);
    eval();
    check_eq("r0_stall_z", 32'(stall1), 32'h0);
    check_eq("r0_stall_nz", 32'(stall0), 32'h1);
    tick();

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
            ($urandom_range(0, 3) == 0) ? 4'b0101 : 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      eval();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, clocked successor to the 16-bit × 8 register file. It provides synchronous writes, asynchronous reset of all registers, two combinational read ports with store-operand steering on port B and an optional write-to-read bypass. A per-register busy scoreboard produces a stall for read-after-write hazards. It sits between decode (read addresses, issue) and writeback (write port) of the RISC pipeline.

## Interface
Parameters:
- DATA_W, 16: register width in bits.
- ADDR_W, 3: register address width; depth = 2**ADDR_W.
- STORE_OP, 4'b0101: opcode value that steers port B to ReadRd.
- ZERO_R0, 0: when 1, register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous active-high reset.
- WE_R, input, 1: writeback enable.
- WrReg_Rd, input, ADDR_W: writeback register address.
- InData_R, input, DATA_W: writeback data.
- ReadA, input, ADDR_W: port A source address.
- ReadB, input, ADDR_W: port B source address for non-store opcodes.
- ReadRd, input, ADDR_W: store data register; used by port B when opcode == STORE_OP.
- opcode, input, 4: decode-stage opcode.
- Issue, input, 1: decode is issuing an instruction this cycle.
- IssueDst, input, ADDR_W: destination register of the issuing instruction.
- IssueWr, input, 1: the issuing instruction writes IssueDst (0 for stores and branches).
- OutA, output, DATA_W: port A read data.
- OutB, output, DATA_W: port B read data.
- Stall, output, 1: hazard; decode must hold and must not issue.

## Operation
- Storage: 2**ADDR_W × DATA_W flip-flops, written on the clock edge, never from a combinational path.
- Write: on posedge clk with WE_R=1, reg[WrReg_Rd] <= InData_R. With ZERO_R0=1, a write to address 0 is dropped.
- Port B address: selB = (opcode == STORE_OP) ? ReadRd : ReadB.
- Reads are combinational:
  - OutA = reg[ReadA]; OutB = reg[selB].
  - With ZERO_R0=1, address 0 reads 0.
- Scoreboard: busy[2**ADDR_W], one bit per register.
  - Set: busy[IssueDst] <= 1 when Issue & IssueWr & ~Stall.
  - Clear: busy[WrReg_Rd] <= 0 when WE_R.
  - Same address set and cleared in one cycle: set wins, because the new producer is outstanding.
- Stall (combinational) = Issue & (hazA | hazB).
  - hazA = busy[ReadA] & ~fwdA; hazB = busy[selB] & ~fwdB.
  - fwdX is defined under Configuration.
  - Register 0 never hazards when ZERO_R0=1.
- The destination is not a hazard source, so WAW is allowed: the busy bit is simply re-set.
- Issue=0 forces Stall=0 and leaves busy unchanged except for writeback clears.

## Timing
- Reset (asynchronous, any time): all registers = 0 and all busy = 0.
  - OutA and OutB read 0 for every address while reset is high and on the first cycle after it.
  - Stall = 0 while reset is high.
- Write latency: 1 cycle. Data written at edge N is visible on reads after edge N (with bypass: during the write cycle).
- Stall is a same-cycle combinational output of Issue, ReadA, ReadB/ReadRd, opcode and state. It has no registered delay.
- A busy bit set at edge N makes Stall assert from cycle N+1 for readers of that register.
- Reset mid-operation discards all pending busy bits. Writebacks in flight arriving after reset write normally; their clears act on already-clear bits.

## Configuration
- REGFILE_BYPASS_EN defined:
  - fwdX = WE_R & (WrReg_Rd == read address of port X).
  - A matching read returns InData_R in the same cycle.
  - That port's hazard is suppressed in the writeback cycle.
- REGFILE_BYPASS_EN undefined:
  - fwdX = 0. Reads always return stored register contents.
  - A reader of a register being written this cycle stalls one more cycle, then reads the new value.

## Test plan
- Reset then read all addresses -> OutA = OutB = 0 for all 8 addresses; Stall = 0.
- Write R3=16'hABCD at edge N; ReadA=3 -> OutA = 16'hABCD from cycle N+1. With bypass: OutA = 16'hABCD already in cycle N.
- opcode=4'b0101, ReadB=1, ReadRd=5, R1=16'h1111, R5=16'h5555 -> OutB = 16'h5555; opcode=4'b0000 -> OutB = 16'h1111.
- Issue IssueDst=2 with IssueWr=1; next cycle Issue with ReadA=2 -> Stall = 1.
  - WE_R with WrReg_Rd=2 in the same cycle: Stall = 0 with bypass; Stall = 1 without, then 0 on the following cycle.
- Same cycle: Issue IssueDst=4 and WE_R WrReg_Rd=4 -> busy[4] = 1 afterwards. Then assert reset asynchronously mid-cycle -> busy cleared, R4 = 0 immediately.
- ZERO_R0=1: write R0=16'hFFFF -> OutA reads 0. Issue IssueDst=0 then read R0 -> Stall = 0.
